// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider. Ratio changes are handshaked and
// take effect only at a period boundary. Odd ratios can get 50% duty via a negedge copy.
module prog_clk_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int ODD_BALANCE = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pending_vld_q, pending_vld_d;
    logic             q_pos_q, q_pos_d;
    logic             q_neg_q;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] half;
    logic             last;
    logic             accept;
    logic             apply;
    logic             odd_sel;

    always_comb begin
        half          = cur_div_q >> 1;
        last          = (cnt_q == cur_div_q - CNT_W'(1));
        accept        = div_valid && !pending_vld_q;

        cnt_d         = cnt_q;
        cur_div_d     = cur_div_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        q_pos_d       = q_pos_q;
        tick_d        = tick_q;
        apply         = 1'b0;

        if (en) begin
            q_pos_d = (cnt_q < half);
            tick_d  = (cnt_q == '0);
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            apply   = last && pending_vld_q;
        end else begin
            cnt_d   = '0;
            q_pos_d = 1'b0;
            tick_d  = 1'b0;
            apply   = pending_vld_q;
        end

        if (apply) begin
            cur_div_d     = pending_q;
            pending_vld_d = 1'b0;
        end

        // accept requires an empty slot, so it never coincides with apply;
        // a request taken on a boundary edge therefore waits for the next boundary
        if (accept) begin
            pending_d     = (div_in < MIN_DIV) ? MIN_DIV : div_in;
            pending_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            cur_div_q     <= RESET_DIV;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            q_pos_q       <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            cur_div_q     <= cur_div_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            q_pos_q       <= q_pos_d;
            tick_q        <= tick_d;
        end
    end

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_pos_q;
        end
    end

    // q_pos and q_neg change on opposite edges, so the OR cannot glitch
    assign odd_sel   = (ODD_BALANCE != 0) && cur_div_q[0];
    assign clk_out   = odd_sel ? (q_pos_q | q_neg_q) : q_pos_q;
    assign tick      = tick_q;
    assign cur_div   = cur_div_q;
    assign div_ready = !pending_vld_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: one instance with odd-ratio balancing,
// one without, sharing stimulus; expected values are hand-derived waveforms.
module tb_prog_clk_divider;

    logic       clk_in;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_valid;

    logic       div_ready,   div_ready_b;
    logic       clk_out,     clk_out_b;
    logic       tick,        tick_b;
    logic [7:0] cur_div,     cur_div_b;

    int n_total = 0;
    int n_pass  = 0;

    prog_clk_divider #(.CNT_W(8), .DEFAULT_DIV(10), .ODD_BALANCE(1)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    prog_clk_divider #(.CNT_W(8), .DEFAULT_DIV(10), .ODD_BALANCE(0)) dut_b (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready_b),
        .clk_out   (clk_out_b),
        .tick      (tick_b),
        .cur_div   (cur_div_b)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    // one clk_in cycle, then compare everything visible at the posedge sample point
    task automatic cyc_chk(input string tag, input logic exp_clk, input logic exp_tick,
                           input logic [7:0] exp_cur, input logic exp_rdy);
        cycle();
        chk({tag, ".clk"},   clk_out,   exp_clk);
        chk({tag, ".clk_b"}, clk_out_b, exp_clk);
        chk({tag, ".tick"},  tick,      exp_tick);
        chk({tag, ".cur"},   cur_div,   exp_cur);
        chk({tag, ".rdy"},   div_ready, exp_rdy);
    endtask

    // even ratio: high for the first period/2 cycles, tick on phase 0
    task automatic period_chk(input string tag, input int period, input int p_from,
                              input int p_to, input logic [7:0] exp_cur, input logic exp_rdy);
        for (int p = p_from; p <= p_to; p++) begin
            cyc_chk(tag, logic'((p % period) < (period / 2)), logic'((p % period) == 0),
                    exp_cur, exp_rdy);
        end
    endtask

    // odd ratio: checks both half-cycles for the balanced and unbalanced instances
    task automatic odd_chk(input string tag, input int n, input logic [15:0] pos_b,
                           input logic [15:0] neg_b, input logic [15:0] ob0_b,
                           input logic [7:0] exp_cur);
        for (int p = 0; p < n; p++) begin
            cycle();
            chk({tag, ".tick"},    tick,      logic'(p == 0));
            chk({tag, ".cur"},     cur_div,   exp_cur);
            chk({tag, ".rdy"},     div_ready, 1'b1);
            chk({tag, ".pos"},     clk_out,   pos_b[p]);
            chk({tag, ".pos_b"},   clk_out_b, ob0_b[p]);
            @(negedge clk_in);
            #1;
            chk({tag, ".neg"},     clk_out,   neg_b[p]);
            chk({tag, ".neg_b"},   clk_out_b, ob0_b[p]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;
        repeat (2) cycle();
        chk("rst.clk",   clk_out,   1'b0);
        chk("rst.clk_b", clk_out_b, 1'b0);
        chk("rst.tick",  tick,      1'b0);
        chk("rst.rdy",   div_ready, 1'b1);
        chk("rst.cur",   cur_div,   8'd10);
        rst = 1'b0;
        cyc_chk("idle", 1'b0, 1'b0, 8'd10, 1'b1);
        en = 1'b1;

        // default ratio 10: high 5 / low 5, tick on the rise
        period_chk("base10", 10, 0, 19, 8'd10, 1'b1);

        // request 4 at cnt=2: current period finishes, then 4-cycle periods
        period_chk("pre4", 10, 0, 1, 8'd10, 1'b1);
        div_valid = 1'b1;
        div_in    = 8'd4;
        cyc_chk("acc4", 1'b1, 1'b0, 8'd10, 1'b0);
        div_valid = 1'b0;
        period_chk("hold4", 10, 3, 8, 8'd10, 1'b0);
        cyc_chk("wrap4", 1'b0, 1'b0, 8'd4, 1'b1);
        period_chk("run4", 4, 0, 7, 8'd4, 1'b1);

        // back-to-back 6 then 8: second is held off until the slot frees
        div_valid = 1'b1;
        div_in    = 8'd6;
        cyc_chk("acc6", 1'b1, 1'b1, 8'd4, 1'b0);
        div_in = 8'd8;
        cyc_chk("b2b1", 1'b1, 1'b0, 8'd4, 1'b0);
        cyc_chk("b2b2", 1'b0, 1'b0, 8'd4, 1'b0);
        cyc_chk("wrap6", 1'b0, 1'b0, 8'd6, 1'b1);
        cyc_chk("acc8", 1'b1, 1'b1, 8'd6, 1'b0);
        div_valid = 1'b0;
        period_chk("run6", 6, 1, 4, 8'd6, 1'b0);
        cyc_chk("wrap8", 1'b0, 1'b0, 8'd8, 1'b1);
        period_chk("run8", 8, 0, 7, 8'd8, 1'b1);

        // odd ratio 3: balanced 1.5/1.5, unbalanced 1/2
        div_valid = 1'b1;
        div_in    = 8'd3;
        cyc_chk("acc3", 1'b1, 1'b1, 8'd8, 1'b0);
        div_valid = 1'b0;
        period_chk("hold3", 8, 1, 6, 8'd8, 1'b0);
        cyc_chk("wrap3", 1'b0, 1'b0, 8'd3, 1'b1);
        odd_chk("odd3a", 3, 16'b011, 16'b001, 16'b001, 8'd3);
        odd_chk("odd3b", 3, 16'b011, 16'b001, 16'b001, 8'd3);

        // div_in=0 clamps to 2
        div_valid = 1'b1;
        div_in    = 8'd0;
        cycle();
        chk("acc0.tick",  tick,      1'b1);
        chk("acc0.cur",   cur_div,   8'd3);
        chk("acc0.rdy",   div_ready, 1'b0);
        chk("acc0.clk",   clk_out,   1'b1);
        chk("acc0.clk_b", clk_out_b, 1'b1);
        div_valid = 1'b0;
        cycle();
        chk("p1.cur",   cur_div,   8'd3);
        chk("p1.clk",   clk_out,   1'b1);
        chk("p1.clk_b", clk_out_b, 1'b0);
        cyc_chk("wrap0", 1'b0, 1'b0, 8'd2, 1'b1);
        period_chk("run2a", 2, 0, 3, 8'd2, 1'b1);

        // div_in=1 clamps to 2 as well
        div_valid = 1'b1;
        div_in    = 8'd1;
        cyc_chk("acc1", 1'b1, 1'b1, 8'd2, 1'b0);
        div_valid = 1'b0;
        cyc_chk("wrap1", 1'b0, 1'b0, 8'd2, 1'b1);
        period_chk("run2b", 2, 0, 3, 8'd2, 1'b1);

        // while disabled, a request applies on the edge after it is accepted
        en        = 1'b0;
        div_valid = 1'b1;
        div_in    = 8'd7;
        cyc_chk("en0acc", 1'b0, 1'b0, 8'd2, 1'b0);
        div_valid = 1'b0;
        cyc_chk("en0app", 1'b0, 1'b0, 8'd7, 1'b1);
        cyc_chk("en0hold", 1'b0, 1'b0, 8'd7, 1'b1);
        @(negedge clk_in);
        #1;
        chk("en0neg.clk", clk_out, 1'b0);
        en = 1'b1;
        odd_chk("odd7", 7, 16'b0001111, 16'b0000111, 16'b0000111, 8'd7);

        // async reset in the high phase discards the pending ratio
        div_valid = 1'b1;
        div_in    = 8'd5;
        cycle();
        chk("pre_rst.clk",  clk_out,   1'b1);
        chk("pre_rst.tick", tick,      1'b1);
        chk("pre_rst.rdy",  div_ready, 1'b0);
        chk("pre_rst.cur",  cur_div,   8'd7);
        div_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst.clk",   clk_out,   1'b0);
        chk("arst.clk_b", clk_out_b, 1'b0);
        chk("arst.tick",  tick,      1'b0);
        chk("arst.rdy",   div_ready, 1'b1);
        chk("arst.cur",   cur_div,   8'd10);
        repeat (2) cycle();
        rst = 1'b0;
        period_chk("post_rst", 10, 0, 19, 8'd10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
